// File: rtl/load_store_unit.sv
// Memory-stage load/store controller: byte/half/word access to a word-wide data memory,
// big-endian lanes, read-modify-write for sub-word stores, one registered response per request.
module load_store_unit #(
    parameter logic [31:0] BASE       = 32'h2400,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WE,
    input  logic [1:0]  REQ_SIZE,
    input  logic        REQ_SIGNED,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] REQ_WDATA,
    output logic        RSP_VALID,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR,
    output logic [31:0] MEM_ADDR,
    output logic        MEM_RW_RD,
    output logic [31:0] MEM_DIN,
    input  logic [31:0] MEM_DOUT
);

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned HALF_W   = 16;
    localparam int unsigned OFF_W    = 2;
    localparam int unsigned SIZE_W   = 2;
    localparam int unsigned WIN_W    = DATA_W + 1;
    localparam logic [WIN_W-1:0] DEPTH_WORDS = WIN_W'(1) << DEPTH_LOG2;

    localparam logic [SIZE_W-1:0] SZ_BYTE = 2'b00;
    localparam logic [SIZE_W-1:0] SZ_HALF = 2'b01;
    localparam logic [SIZE_W-1:0] SZ_WORD = 2'b10;
    localparam logic [SIZE_W-1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RD_CAP,
        S_RMW_RD,
        S_RMW_MERGE,
        S_WR,
        S_RESP
    } state_t;

    // Request fields still needed after the accept edge.
    typedef struct packed {
        logic [SIZE_W-1:0] size;
        logic              sgn;
        logic [OFF_W-1:0]  off;
        logic [HALF_W-1:0] wdata;
    } req_t;

    state_t state_q;
    state_t state_d;
    req_t   req_q;
    req_t   req_d;

    logic              accept_c;
    logic              err_c;
    logic [DATA_W-1:0] byte_off_c;
    logic [DATA_W-1:0] word_off_c;
    logic [DATA_W-1:0] word_addr_c;

    logic              ready_d;
    logic              rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_d;
    logic              rsp_err_d;
    logic [DATA_W-1:0] mem_addr_d;
    logic              mem_rw_rd_d;
    logic [DATA_W-1:0] mem_din_d;

    // Big-endian lane select and sign/zero extension of a loaded word.
    function automatic logic [DATA_W-1:0] lane_extract(
        input logic [DATA_W-1:0] word,
        input logic [SIZE_W-1:0] size,
        input logic [OFF_W-1:0]  off,
        input logic              sgn
    );
        logic [7:0]        b;
        logic [HALF_W-1:0] h;
        logic [DATA_W-1:0] r;
        b = 8'(word >> {~off, 3'b000});
        h = off[1] ? word[15:0] : word[31:16];
        case (size)
            SZ_BYTE: r = {{24{sgn & b[7]}}, b};
            SZ_HALF: r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed big-endian lane of the old word with the store data.
    function automatic logic [DATA_W-1:0] lane_merge(
        input logic [DATA_W-1:0] word,
        input logic [SIZE_W-1:0] size,
        input logic [OFF_W-1:0]  off,
        input logic [HALF_W-1:0] wdata
    );
        logic [DATA_W-1:0] mask;
        logic [DATA_W-1:0] r;
        if (size == SZ_BYTE) begin
            mask = DATA_W'(8'hFF) << {~off, 3'b000};
            r    = (word & ~mask) | (DATA_W'(wdata[7:0]) << {~off, 3'b000});
        end else begin
            r = off[1] ? {word[31:16], wdata} : {wdata, word[15:0]};
        end
        return r;
    endfunction

    assign accept_c    = REQ_VALID && REQ_READY;
    assign byte_off_c  = REQ_ADDR - BASE;
    assign word_off_c  = byte_off_c >> 2;
    assign word_addr_c = BASE + word_off_c;

    // Illegal size, misalignment and window checks collapse into one reject flag.
    always_comb begin
        err_c = 1'b0;
        if (REQ_SIZE == SZ_ILL) begin
            err_c = 1'b1;
        end else if ((REQ_SIZE == SZ_HALF && REQ_ADDR[0]) ||
                     (REQ_SIZE == SZ_WORD && REQ_ADDR[1:0] != 2'b00)) begin
            err_c = 1'b1;
        end else if ((REQ_ADDR < BASE) || ({1'b0, word_off_c} >= DEPTH_WORDS)) begin
            err_c = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    if (err_c) begin
                        state_d = S_RESP;
                    end else if (!REQ_WE) begin
                        state_d = S_RD;
                    end else if (REQ_SIZE == SZ_WORD) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_RD:        state_d = S_RD_CAP;
            S_RD_CAP:    state_d = S_RESP;
            S_RMW_RD:    state_d = S_RMW_MERGE;
            S_RMW_MERGE: state_d = S_WR;
            S_WR:        state_d = S_RESP;
            S_RESP:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Next values of every registered output; response fields change only when entering RESP.
    always_comb begin
        ready_d     = (state_d == S_IDLE);
        rsp_valid_d = (state_q == S_RESP);
        mem_rw_rd_d = (state_d != S_WR);
        rsp_rdata_d = RSP_RDATA;
        rsp_err_d   = RSP_ERR;
        mem_addr_d  = MEM_ADDR;
        mem_din_d   = MEM_DIN;
        req_d       = req_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    req_d.size  = REQ_SIZE;
                    req_d.sgn   = REQ_SIGNED;
                    req_d.off   = REQ_ADDR[1:0];
                    req_d.wdata = REQ_WDATA[15:0];
                    if (err_c) begin
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                    end else begin
                        mem_addr_d = word_addr_c;
                        if (REQ_WE && REQ_SIZE == SZ_WORD) begin
                            mem_din_d = REQ_WDATA;
                        end
                    end
                end
            end
            S_RD_CAP: begin
                rsp_rdata_d = lane_extract(MEM_DOUT, req_q.size, req_q.off, req_q.sgn);
                rsp_err_d   = 1'b0;
            end
            S_RMW_MERGE: begin
                mem_din_d = lane_merge(MEM_DOUT, req_q.size, req_q.off, req_q.wdata);
            end
            S_WR: begin
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            REQ_READY <= 1'b1;
            RSP_VALID <= 1'b0;
            RSP_RDATA <= '0;
            RSP_ERR   <= 1'b0;
            MEM_ADDR  <= BASE;
            MEM_RW_RD <= 1'b1;
            MEM_DIN   <= '0;
            req_q     <= '0;
        end else begin
            REQ_READY <= ready_d;
            RSP_VALID <= rsp_valid_d;
            RSP_RDATA <= rsp_rdata_d;
            RSP_ERR   <= rsp_err_d;
            MEM_ADDR  <= mem_addr_d;
            MEM_RW_RD <= mem_rw_rd_d;
            MEM_DIN   <= mem_din_d;
            req_q     <= req_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory model on the memory port, byte-array reference
// model for expected load data, errors, latency and write-cycle counts.
module tb_load_store_unit;

    localparam logic [31:0] BASE  = 32'h2400;
    localparam int          DEPTH = 1024;

    logic        CLK;
    logic        RST_N;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_WE;
    logic [1:0]  REQ_SIZE;
    logic        REQ_SIGNED;
    logic [31:0] REQ_ADDR;
    logic [31:0] REQ_WDATA;
    logic        RSP_VALID;
    logic [31:0] RSP_RDATA;
    logic        RSP_ERR;
    logic [31:0] MEM_ADDR;
    logic        MEM_RW_RD;
    logic [31:0] MEM_DIN;
    logic [31:0] MEM_DOUT;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.BASE(BASE), .DEPTH_LOG2(10)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
        .REQ_SIZE(REQ_SIZE), .REQ_SIGNED(REQ_SIGNED), .REQ_ADDR(REQ_ADDR),
        .REQ_WDATA(REQ_WDATA), .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA),
        .RSP_ERR(RSP_ERR), .MEM_ADDR(MEM_ADDR), .MEM_RW_RD(MEM_RW_RD),
        .MEM_DIN(MEM_DIN), .MEM_DOUT(MEM_DOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Data memory: word index = ADDR - BASE, synchronous write, registered read.
    logic [31:0] dmem [0:DEPTH-1];
    logic [31:0] moff;
    assign moff = MEM_ADDR - BASE;
    always @(posedge CLK) begin
        if (moff < 32'(DEPTH)) begin
            if (!MEM_RW_RD) dmem[10'(moff)] <= MEM_DIN;
            else            MEM_DOUT <= dmem[10'(moff)];
        end
    end

    // Reference memory as big-endian bytes: byte address BASE+k lives at ref_bytes[k].
    logic [7:0] ref_bytes [0:4*DEPTH-1];

    task automatic ref_model(input logic we, input logic [1:0] size, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rdata, output logic err,
                             output int lat, output int writes);
        int n;
        logic [31:0] off;
        logic [31:0] v;
        off = addr - BASE;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        err = (size == 2'd3) || ((addr % 32'(n)) != 0) || (addr < BASE) ||
              (off >= 32'(4 * DEPTH));
        rdata = 0;
        writes = 0;
        if (err) begin
            lat = 2;
        end else if (we) begin
            for (int i = 0; i < n; i++)
                ref_bytes[12'(off + 32'(i))] = 8'(wdata >> (8 * (n - 1 - i)));
            lat = (n == 4) ? 3 : 5;
            writes = 1;
        end else begin
            v = 0;
            for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_bytes[12'(off + 32'(i))]);
            if (sgn && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
            rdata = v;
            lat = 4;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // One request; latency counts cycles from the accept cycle to the RSP_VALID cycle.
    task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err, output logic rdy,
                           output int lat, output int writes, output logic seen);
        @(negedge CLK);
        REQ_VALID = 1'b1; REQ_WE = we; REQ_SIZE = size; REQ_SIGNED = sgn;
        REQ_ADDR = addr; REQ_WDATA = wdata;
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0; REQ_WE = ~we; REQ_SIZE = ~size; REQ_SIGNED = ~sgn;
        REQ_ADDR = $urandom; REQ_WDATA = $urandom;
        lat = 1; writes = 0; seen = 1'b0; rdata = 0; err = 1'b0; rdy = 1'b0;
        while (!seen && lat <= 12) begin
            if (!MEM_RW_RD) writes++;
            if (RSP_VALID) begin
                seen = 1'b1; rdata = RSP_RDATA; err = RSP_ERR; rdy = REQ_READY;
            end else begin
                @(posedge CLK);
                #1;
                lat++;
            end
        end
    endtask

    task automatic do_check(input string tag, input logic we, input logic [1:0] size,
                            input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rdata, input logic exp_err,
                            input int exp_lat, input int exp_wr);
        logic [31:0] rdata;
        logic err, rdy, seen;
        int lat, writes;
        run_req(we, size, sgn, addr, wdata, rdata, err, rdy, lat, writes, seen);
        chk({tag, " rsp_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
            chk({tag, " rdata"}, rdata, exp_rdata);
            chk({tag, " err"}, 32'(err), 32'(exp_err));
            chk({tag, " ready_with_rsp"}, 32'(rdy), 32'd1);
        end
        chk({tag, " write_cycles"}, 32'(writes), 32'(exp_wr));
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_wr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        v.exp_lat = exp_err ? 2 : !we ? 4 : (size == 2'd2) ? 3 : 5;
        v.exp_wr = (we && !exp_err) ? 1 : 0;
        vecs.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r_rdata;
        logic r_err;
        int r_lat, r_wr, pulses;
        logic we, sgn;
        logic [1:0] size;
        logic [31:0] addr, wdata;
        int sel;

        for (int i = 0; i < DEPTH; i++) dmem[i] = 32'd0;
        for (int i = 0; i < 4 * DEPTH; i++) ref_bytes[i] = 8'd0;
        dmem[2] = 32'd2001;
        ref_bytes[10] = 8'h07;
        ref_bytes[11] = 8'hD1;

        RST_N = 1'b0; REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_SIZE = 2'd0;
        REQ_SIGNED = 1'b0; REQ_ADDR = 32'd0; REQ_WDATA = 32'd0;
        #12;
        chk("reset REQ_READY", 32'(REQ_READY), 32'd1);
        chk("reset RSP_VALID", 32'(RSP_VALID), 32'd0);
        chk("reset RSP_RDATA", RSP_RDATA, 32'd0);
        chk("reset RSP_ERR", 32'(RSP_ERR), 32'd0);
        chk("reset MEM_RW_RD", 32'(MEM_RW_RD), 32'd1);
        chk("reset MEM_ADDR", MEM_ADDR, BASE);
        chk("reset MEM_DIN", MEM_DIN, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        //  we    size   sgn   addr          wdata          exp_rdata      err
        add(1'b0, 2'd2, 1'b0, 32'h2408, 32'h0,         32'h0000_07D1, 1'b0);
        add(1'b0, 2'd0, 1'b1, 32'h240B, 32'h0,         32'hFFFF_FFD1, 1'b0);
        add(1'b0, 2'd0, 1'b0, 32'h240B, 32'h0,         32'h0000_00D1, 1'b0);
        add(1'b0, 2'd1, 1'b1, 32'h240A, 32'h0,         32'h0000_07D1, 1'b0);
        add(1'b0, 2'd0, 1'b1, 32'h2408, 32'h0,         32'h0000_0000, 1'b0);
        add(1'b1, 2'd0, 1'b0, 32'h2409, 32'h0000_00AB, 32'h0,         1'b0);
        add(1'b0, 2'd2, 1'b0, 32'h2408, 32'h0,         32'h00AB_07D1, 1'b0);
        add(1'b1, 2'd2, 1'b0, 32'h240C, 32'hDEAD_BEEF, 32'h0,         1'b0);
        add(1'b0, 2'd1, 1'b1, 32'h240C, 32'h0,         32'hFFFF_DEAD, 1'b0);
        add(1'b0, 2'd2, 1'b0, 32'h240C, 32'h0,         32'hDEAD_BEEF, 1'b0);
        add(1'b0, 2'd1, 1'b0, 32'h240E, 32'h0,         32'h0000_BEEF, 1'b0);
        add(1'b0, 2'd0, 1'b1, 32'h240D, 32'h0,         32'hFFFF_FFAD, 1'b0);
        add(1'b1, 2'd1, 1'b0, 32'h240E, 32'hFFFF_1234, 32'h0,         1'b0);
        add(1'b0, 2'd2, 1'b0, 32'h240C, 32'h0,         32'hDEAD_1234, 1'b0);
        add(1'b0, 2'd1, 1'b1, 32'h240E, 32'h0,         32'h0000_1234, 1'b0);
        add(1'b0, 2'd2, 1'b0, 32'h2402, 32'h0,         32'h0,         1'b1);
        add(1'b1, 2'd1, 1'b0, 32'h2405, 32'h0000_5555, 32'h0,         1'b1);
        add(1'b0, 2'd3, 1'b0, 32'h2408, 32'h0,         32'h0,         1'b1);
        add(1'b0, 2'd2, 1'b0, 32'h2000, 32'h0,         32'h0,         1'b1);
        add(1'b1, 2'd2, 1'b0, 32'h2409, 32'hFFFF_FFFF, 32'h0,         1'b1);
        add(1'b1, 2'd3, 1'b0, 32'h2408, 32'hFFFF_FFFF, 32'h0,         1'b1);
        add(1'b0, 2'd2, 1'b0, 32'h3400, 32'h0,         32'h0,         1'b1);
        add(1'b0, 2'd2, 1'b0, 32'h2408, 32'h0,         32'h00AB_07D1, 1'b0);
        add(1'b0, 2'd2, 1'b0, 32'h33FC, 32'h0,         32'h0000_0000, 1'b0);
        add(1'b1, 2'd0, 1'b0, 32'h33FF, 32'h0000_0077, 32'h0,         1'b0);
        add(1'b0, 2'd2, 1'b0, 32'h33FC, 32'h0,         32'h0000_0077, 1'b0);
        add(1'b1, 2'd0, 1'b0, 32'h2410, 32'h1234_56C3, 32'h0,         1'b0);
        add(1'b0, 2'd0, 1'b0, 32'h2410, 32'h0,         32'h0000_00C3, 1'b0);
        add(1'b0, 2'd0, 1'b1, 32'h2410, 32'h0,         32'hFFFF_FFC3, 1'b0);
        add(1'b0, 2'd2, 1'b0, 32'h2410, 32'h0,         32'hC300_0000, 1'b0);

        foreach (vecs[i]) begin
            ref_model(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                      r_rdata, r_err, r_lat, r_wr);
            do_check($sformatf("vec%0d", i), vecs[i].we, vecs[i].size, vecs[i].sgn,
                     vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err,
                     vecs[i].exp_lat, vecs[i].exp_wr);
        end

        // Response fields hold after the pulse.
        repeat (2) @(posedge CLK);
        #1;
        chk("hold RSP_VALID", 32'(RSP_VALID), 32'd0);
        chk("hold RSP_RDATA", RSP_RDATA, 32'hC300_0000);

        // Reset one cycle into a sub-word store.
        @(negedge CLK);
        REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_SIZE = 2'd0; REQ_SIGNED = 1'b0;
        REQ_ADDR = 32'h2408; REQ_WDATA = 32'h55;
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
        @(posedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        chk("rst_sb MEM_RW_RD", 32'(MEM_RW_RD), 32'd1);
        chk("rst_sb REQ_READY", 32'(REQ_READY), 32'd1);
        chk("rst_sb RSP_VALID", 32'(RSP_VALID), 32'd0);
        chk("rst_sb RSP_RDATA", RSP_RDATA, 32'd0);
        chk("rst_sb RSP_ERR", 32'(RSP_ERR), 32'd0);
        chk("rst_sb MEM_ADDR", MEM_ADDR, BASE);
        chk("rst_sb MEM_DIN", MEM_DIN, 32'd0);
        pulses = 0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        repeat (8) begin
            @(posedge CLK);
            #1;
            if (RSP_VALID) pulses++;
        end
        chk("rst_sb no_rsp", 32'(pulses), 32'd0);
        do_check("rst_sb readback", 1'b0, 2'd2, 1'b0, 32'h2408, 32'h0, 32'h00AB_07D1, 1'b0, 4, 0);

        // Reset during the write cycle of a word store.
        @(negedge CLK);
        REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_SIZE = 2'd2; REQ_SIGNED = 1'b0;
        REQ_ADDR = 32'h2408; REQ_WDATA = 32'hFFFF_FFFF;
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
        chk("rst_sw in_write", 32'(MEM_RW_RD), 32'd0);
        RST_N = 1'b0;
        #1;
        chk("rst_sw MEM_RW_RD", 32'(MEM_RW_RD), 32'd1);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        do_check("rst_sw readback", 1'b0, 2'd2, 1'b0, 32'h2408, 32'h0, 32'h00AB_07D1, 1'b0, 4, 0);

        // Randomized traffic against the byte-level reference.
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 15);
            size = (sel < 5) ? 2'd0 : (sel < 10) ? 2'd1 : (sel < 15) ? 2'd2 : 2'd3;
            we = 1'($urandom_range(0, 1));
            sgn = 1'($urandom_range(0, 1));
            wdata = $urandom;
            sel = $urandom_range(0, 15);
            if (sel == 0)      addr = BASE - 32'($urandom_range(1, 64));
            else if (sel == 1) addr = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 64));
            else               addr = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
            if (sel > 3) begin
                if (size == 2'd1) addr[0] = 1'b0;
                if (size == 2'd2) addr[1:0] = 2'b00;
            end
            ref_model(we, size, sgn, addr, wdata, r_rdata, r_err, r_lat, r_wr);
            do_check($sformatf("rnd%0d", n), we, size, sgn, addr, wdata, r_rdata, r_err,
                     r_lat, r_wr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
